input_conditioner: RTL and testbench

Front-end stage feeding the game datapath's user-command inputs `c_attack`, `c_up`, `c_down`, `c_left` and `c_right`. It takes raw board inputs (KEY[3:0], active-low; SW[0]), then synchronizes and debounces them. Presses shorter than a frame are captured so they are not lost between frames. It presents one stable, priority-resolved command set per frame, sampled on the control FSM's `gen_move` pulse.

---
 rtl/game_pkg.sv | 42 ++++
 rtl/debounce_channel.sv | 71 +++++++
 rtl/input_conditioner.sv | 69 ++++++
 tb/tb_input_conditioner.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: action encodings, input channel indices and
// input-conditioner defaults used by the datapath and collision logic.
package game_pkg;

    typedef enum logic [2:0] {
        NO_ACTION = 3'b000,
        ATTACK    = 3'b001,
        UP        = 3'b010,
        DOWN      = 3'b011,
        LEFT      = 3'b100,
        RIGHT     = 3'b101
    } action_e;

    localparam int NUM_CH    = 5;
    localparam int CH_RIGHT  = 0;
    localparam int CH_LEFT   = 1;
    localparam int CH_DOWN   = 2;
    localparam int CH_UP     = 3;
    localparam int CH_ATTACK = 4;

    // 10 ms at 50 MHz; the counter width must hold DEBOUNCE_CYCLES-1
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_CNT_W           = 20;

    // Bit order matches the channel indices: attack is the MSB, right the LSB.
    typedef struct packed {
        logic attack;
        logic up;
        logic down;
        logic left;
        logic right;
    } cmd_t;

    function automatic action_e resolve_direction(input cmd_t raw);
        if (raw.up)    return UP;
        if (raw.down)  return DOWN;
        if (raw.left)  return LEFT;
        if (raw.right) return RIGHT;
        return NO_ACTION;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input: two-flop synchronizer, debounce counter, accepted
// level, press-edge pulse and a sticky press flag cleared by sample.
module debounce_channel
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    input  logic sample,
    output logic stable,
    output logic raw,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;
    logic             sticky;
    logic             differs;
    logic             accept;
    logic             stable_next;
    logic             rise;

    assign differs     = sync ^ stable;
    assign accept      = differs && (cnt == CNT_LAST);
    assign stable_next = accept ? sync : stable;
    assign rise        = stable_next & ~stable;
    // A press edge landing on the sample edge is folded in through stable_next.
    assign raw         = stable_next | sticky;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, as the hardware does.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= din;
            sync      <= sync_meta;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            stable <= 1'b0;
            press  <= 1'b0;
            sticky <= 1'b0;
        end else begin
            if (!differs || accept) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            stable <= stable_next;
            press  <= rise;
            // Sample wins over a coincident edge: that edge is already in raw.
            if (sample) begin
                sticky <= 1'b0;
            end else if (rise) begin
                sticky <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Board-input front end: five debounced channels feeding a per-frame sample
// register with up > down > left > right direction priority.
module input_conditioner
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  key_n,
    input  logic        sw_attack,
    input  logic        sample,
    output logic        c_attack,
    output logic        c_up,
    output logic        c_down,
    output logic        c_left,
    output logic        c_right,
    output logic [4:0]  press_pulse,
    output logic        any_active
);

    logic [NUM_CH-1:0] din_vec;
    logic [NUM_CH-1:0] stable_vec;
    logic [NUM_CH-1:0] raw_vec;
    logic [NUM_CH-1:0] press_vec;
    cmd_t              raw;
    action_e           dir;

    // Keys are active-low on the board; everything downstream is active-high.
    assign din_vec = {sw_attack, ~key_n};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clock  (clock),
            .reset  (reset),
            .din    (din_vec[i]),
            .sample (sample),
            .stable (stable_vec[i]),
            .raw    (raw_vec[i]),
            .press  (press_vec[i])
        );
    end

    assign raw         = cmd_t'(raw_vec);
    assign dir         = resolve_direction(raw);
    assign press_pulse = press_vec;
    assign any_active  = |stable_vec;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            c_attack <= 1'b0;
            c_up     <= 1'b0;
            c_down   <= 1'b0;
            c_left   <= 1'b0;
            c_right  <= 1'b0;
        end else if (sample) begin
            c_attack <= raw.attack;
            c_up     <= (dir == UP);
            c_down   <= (dir == DOWN);
            c_left   <= (dir == LEFT);
            c_right  <= (dir == RIGHT);
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEBOUNCE_CYCLES=4: vector table, directed
// corner sequences and random stimulus against a history-window model.
module tb_input_conditioner;

    localparam int DC = 4;

    typedef struct {
        logic [3:0] key_n;
        logic       sw;
        logic [4:0] exp_cmd;   // {attack, up, down, left, right}
    } vec_t;

    logic       clock     = 1'b0;
    logic       reset     = 1'b0;
    logic [3:0] key_n     = 4'hF;
    logic       sw_attack = 1'b0;
    logic       sample    = 1'b0;
    logic       c_attack, c_up, c_down, c_left, c_right;
    logic [4:0] press_pulse;
    logic       any_active;

    int n_checks;
    int n_fail;

    // Reference model state
    logic [4:0] hist[$];
    logic [4:0] m_stable;
    logic [4:0] m_sticky;
    logic [4:0] m_press;
    logic [4:0] m_cmd;

    vec_t vecs[7];

    input_conditioner #(
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key_n       (key_n),
        .sw_attack   (sw_attack),
        .sample      (sample),
        .c_attack    (c_attack),
        .c_up        (c_up),
        .c_down      (c_down),
        .c_left      (c_left),
        .c_right     (c_right),
        .press_pulse (press_pulse),
        .any_active  (any_active)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_stable = '0;
        m_sticky = '0;
        m_press  = '0;
        m_cmd    = '0;
    endtask

    // A level is accepted once the synchronized input (input delayed two
    // edges) has differed from the accepted level for DC edges in a row.
    task automatic model_edge();
        logic [4:0] nxt;
        logic [4:0] rise;
        logic [4:0] raw;
        bit         flip;
        logic       v;
        int         idx;
        if (!reset) return;
        hist.push_back({sw_attack, ~key_n});
        for (int ch = 0; ch < 5; ch++) begin
            flip = 1'b1;
            for (int j = 0; j < DC; j++) begin
                idx = hist.size() - 3 - j;
                v   = (idx >= 0) ? hist[idx][ch] : 1'b0;
                if (v == m_stable[ch]) flip = 1'b0;
            end
            nxt[ch] = flip ? ~m_stable[ch] : m_stable[ch];
        end
        rise = nxt & ~m_stable;
        raw  = nxt | m_sticky;
        if (sample) begin
            m_cmd[4]   = raw[4];
            m_cmd[3:0] = raw[3] ? 4'b1000 : raw[2] ? 4'b0100 :
                         raw[1] ? 4'b0010 : raw[0] ? 4'b0001 : 4'b0000;
            m_sticky   = '0;
        end else begin
            m_sticky = m_sticky | rise;
        end
        m_press  = rise;
        m_stable = nxt;
        while (hist.size() > 16) void'(hist.pop_front());
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check("model cmd", {27'd0, c_attack, c_up, c_down, c_left, c_right}, {27'd0, m_cmd});
        check("model press_pulse", {27'd0, press_pulse}, {27'd0, m_press});
        check("model any_active", {31'd0, any_active}, {31'd0, |m_stable});
    endtask

    task automatic do_sample();
        sample = 1'b1;
        tick();
        sample = 1'b0;
    endtask

    task automatic settle();
        key_n     = 4'hF;
        sw_attack = 1'b0;
        repeat (DC + 4) tick();
        do_sample();
        do_sample();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] cmd;
        logic       seen;
        n_checks = 0;
        n_fail   = 0;
        model_reset();

        vecs[0] = '{4'b1111, 1'b0, 5'b00000};
        vecs[1] = '{4'b0110, 1'b1, 5'b11000};
        vecs[2] = '{4'b1110, 1'b0, 5'b00001};
        vecs[3] = '{4'b1100, 1'b0, 5'b00010};
        vecs[4] = '{4'b1010, 1'b0, 5'b00100};
        vecs[5] = '{4'b0000, 1'b1, 5'b11000};
        vecs[6] = '{4'b1101, 1'b1, 5'b10010};

        // Power-on reset
        repeat (3) tick();
        check("por cmd", {27'd0, c_attack, c_up, c_down, c_left, c_right}, 32'd0);
        check("por press", {27'd0, press_pulse}, 32'd0);
        check("por active", {31'd0, any_active}, 32'd0);
        reset = 1'b1;
        settle();

        // Vector table: press, sample, release, hold check, sample again
        for (int i = 0; i < 7; i++) begin
            key_n     = vecs[i].key_n;
            sw_attack = vecs[i].sw;
            repeat (DC + 4) tick();
            do_sample();
            cmd = {c_attack, c_up, c_down, c_left, c_right};
            check($sformatf("vec%0d cmd", i), {27'd0, cmd}, {27'd0, vecs[i].exp_cmd});
            key_n     = 4'hF;
            sw_attack = 1'b0;
            repeat (DC + 4) tick();
            cmd = {c_attack, c_up, c_down, c_left, c_right};
            check($sformatf("vec%0d hold", i), {27'd0, cmd}, {27'd0, vecs[i].exp_cmd});
            do_sample();
            cmd = {c_attack, c_up, c_down, c_left, c_right};
            check($sformatf("vec%0d release", i), {27'd0, cmd}, 32'd0);
        end

        // Reset mid-operation with up held
        key_n = 4'b0111;
        repeat (10) tick();
        do_sample();
        check("rst pre up", {31'd0, c_up}, 32'd1);
        reset = 1'b0;
        model_reset();
        #1;
        cmd = {c_attack, c_up, c_down, c_left, c_right};
        check("rst cmd", {27'd0, cmd}, 32'd0);
        check("rst press", {27'd0, press_pulse}, 32'd0);
        check("rst active", {31'd0, any_active}, 32'd0);
        repeat (3) tick();
        reset = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("rst up early", {31'd0, press_pulse[3]}, 32'd0);
        end
        tick();
        check("rst up pulse", {31'd0, press_pulse[3]}, 32'd1);
        do_sample();
        check("rst up cmd", {31'd0, c_up}, 32'd1);
        settle();

        // Glitch rejection on left
        seen  = 1'b0;
        key_n = 4'b1101;
        repeat (3) begin
            tick();
            seen = seen | press_pulse[1];
        end
        key_n = 4'hF;
        repeat (10) begin
            tick();
            seen = seen | press_pulse[1];
        end
        check("glitch press", {31'd0, seen}, 32'd0);
        do_sample();
        check("glitch left", {31'd0, c_left}, 32'd0);
        settle();

        // Held up, sample at cycle 10
        key_n = 4'b0111;
        for (int c = 1; c <= 20; c++) begin
            sample = (c == 10);
            tick();
            if (c >= 10) check($sformatf("held up c%0d", c), {31'd0, c_up}, 32'd1);
        end
        sample = 1'b0;
        key_n  = 4'hF;
        repeat (10) tick();
        check("held hold", {31'd0, c_up}, 32'd1);
        do_sample();
        check("held release", {31'd0, c_up}, 32'd0);
        settle();

        // Sub-frame tap on right
        key_n = 4'b1110;
        repeat (8) tick();
        key_n = 4'hF;
        repeat (30) tick();
        check("tap before", {31'd0, c_right}, 32'd0);
        do_sample();
        check("tap first", {31'd0, c_right}, 32'd1);
        do_sample();
        check("tap second", {31'd0, c_right}, 32'd0);
        settle();

        // Priority: up + right + attack
        key_n     = 4'b0110;
        sw_attack = 1'b1;
        repeat (10) tick();
        do_sample();
        check("prio up", {31'd0, c_up}, 32'd1);
        check("prio right", {31'd0, c_right}, 32'd0);
        check("prio attack", {31'd0, c_attack}, 32'd1);
        settle();

        // Sample coincident with the down acceptance edge
        key_n = 4'b1011;
        repeat (5) tick();
        sample = 1'b1;
        tick();
        sample = 1'b0;
        check("coin down", {31'd0, c_down}, 32'd1);
        check("coin pulse", {31'd0, press_pulse[2]}, 32'd1);
        key_n = 4'hF;
        repeat (10) tick();
        do_sample();
        check("coin release", {31'd0, c_down}, 32'd0);
        settle();

        // Random stimulus, including occasional async resets
        repeat (1500) begin
            if ($urandom_range(0, 7) == 0) begin
                key_n     = 4'($urandom);
                sw_attack = 1'($urandom);
            end
            sample = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b0;
                model_reset();
            end else begin
                reset = 1'b1;
            end
            tick();
        end
        reset  = 1'b1;
        sample = 1'b0;
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
